// File: rtl/fifo_wr_arbiter_if.sv
// Purpose: bundles the requester, grant and FIFO write-port signals of fifo_wr_arbiter.
// Latency: n/a (wiring only).
// Backpressure: fifo_full from the FIFO side stalls the granted requester.
interface fifo_wr_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        ack;
    logic                    fifo_full;
    logic                    fifo_wr_en;
    logic [DATA_W-1:0]       fifo_wr_data;
    logic [ID_W-1:0]         owner_id;
    logic [N_REQ*16-1:0]     wr_cnt;

    // Arbiter side
    modport master (
        input  req, req_data, fifo_full,
        output gnt, ack, fifo_wr_en, fifo_wr_data, owner_id, wr_cnt
    );

    // Requesters / FIFO side
    modport slave (
        output req, req_data, fifo_full,
        input  gnt, ack, fifo_wr_en, fifo_wr_data, owner_id, wr_cnt
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Purpose: round-robin arbiter sharing one FIFO write port among N_REQ producers, bursts of up to MAX_BURST words.
// Latency: grant registered 1 cycle after req in IDLE; wr_en/ack/data combinational from the held grant.
// Backpressure: fifo_full blocks every ack and freezes the grant and burst count; optional stats via FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    fifo_wr_arbiter_if.master bus
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t            r_state, w_state_nxt;
    logic [N_REQ-1:0]  r_gnt, w_gnt_nxt;
    logic [ID_W-1:0]   r_owner, w_owner_nxt;
    logic [ID_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
    logic [3:0]        r_burst, w_burst_nxt;

    logic [N_REQ-1:0]  w_ack;
    logic [ID_W-1:0]   w_arb_ptr;
    logic [ID_W-1:0]   w_win;
    logic              w_found;
    logic              w_owner_req;
    logic              w_last_beat;
    logic              w_release;

    // First set bit of vec scanning ptr+1, ptr+2, ... (mod N_REQ); returns {found, index}.
    function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] vec,
                                              input logic [ID_W-1:0]  ptr);
        logic [ID_W:0] res;
        int            idx;
        res = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!res[ID_W] && vec[ID_W'(idx)]) begin
                res = {1'b1, ID_W'(idx)};
            end
        end
        return res;
    endfunction

    // Accept/release decode and round-robin search; on a req drop the owner bit is already clear in req.
    always_comb begin
        w_ack       = r_gnt & bus.req & {N_REQ{~bus.fifo_full}};
        w_owner_req = bus.req[r_owner];
        w_last_beat = w_ack[r_owner] && (r_burst == 4'(MAX_BURST - 1));
        w_release   = (r_state == S_BUSY) && (!w_owner_req || w_last_beat);
        w_arb_ptr   = (r_state == S_IDLE) ? r_rr_ptr : r_owner;
        {w_found, w_win} = rr_pick(bus.req, w_arb_ptr);
    end

    // Next-state: grant hand-off happens in the release cycle so there is no idle bubble.
    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_nxt    = r_gnt;
        w_owner_nxt  = r_owner;
        w_rr_ptr_nxt = r_rr_ptr;
        w_burst_nxt  = r_burst;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_BUSY;
                    w_gnt_nxt   = N_REQ'(1) << w_win;
                    w_owner_nxt = w_win;
                    w_burst_nxt = '0;
                end
            end
            S_BUSY: begin
                if (w_release) begin
                    w_rr_ptr_nxt = r_owner;
                    w_burst_nxt  = '0;
                    if (w_found) begin
                        w_gnt_nxt   = N_REQ'(1) << w_win;
                        w_owner_nxt = w_win;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_gnt_nxt   = '0;
                        w_owner_nxt = '0;
                    end
                end else if (|w_ack) begin
                    w_burst_nxt = r_burst + 4'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = '0;
                w_owner_nxt = '0;
                w_burst_nxt = '0;
            end
        endcase
    end

    // Arbiter state register; rr_ptr starts at N_REQ-1 so requester 0 wins first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_gnt    <= '0;
            r_owner  <= '0;
            r_rr_ptr <= ID_W'(N_REQ - 1);
            r_burst  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_gnt    <= w_gnt_nxt;
            r_owner  <= w_owner_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            r_burst  <= w_burst_nxt;
        end
    end

    assign bus.gnt          = r_gnt;
    assign bus.ack          = w_ack;
    assign bus.owner_id     = r_owner;
    assign bus.fifo_wr_en   = |w_ack;
    assign bus.fifo_wr_data = (r_state == S_BUSY) ? bus.req_data[r_owner*DATA_W +: DATA_W]
                                                  : '0;

`ifdef FIFO_WR_ARB_STATS_EN
    logic [N_REQ*16-1:0] r_wr_cnt;

    // Per-requester saturating write counters, cleared only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_cnt <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (w_ack[i] && (r_wr_cnt[i*16 +: 16] != 16'hFFFF)) begin
                    r_wr_cnt[i*16 +: 16] <= r_wr_cnt[i*16 +: 16] + 16'd1;
                end
            end
        end
    end

    assign bus.wr_cnt = r_wr_cnt;
`else
    assign bus.wr_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Purpose: self-checking bench for fifo_wr_arbiter against a behavioural round-robin model.
// Latency: checks every cycle, 1 time unit after the driving negedge.
// Backpressure: fifo_full driven both in directed windows and randomly.
module tb_fifo_wr_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic reset_n;

    fifo_wr_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus ();

    fifo_wr_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Requester side: words remaining and current word per requester.
    int          rem [N];
    logic [7:0]  cur [N];
    logic        full;
    logic [N-1:0]    v_req;
    logic [N*DW-1:0] v_dat;

    // Reference model: owner = -1 when idle.
    int m_owner, m_burst, m_ptr;
    int m_cnt [N];
    logic [N-1:0] e_ack;
    logic [63:0]  e_cnt;
    int wr_seen;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 1; k <= N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_burst = 0;
        m_ptr   = N - 1;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            v_req[i] = (rem[i] > 0);
            v_dat[i*DW +: DW] = cur[i];
        end
        bus.req       = v_req;
        bus.req_data  = v_dat;
        bus.fifo_full = full;
    endtask

    // One clock cycle: drive, check outputs against the model, advance model and requesters.
    task automatic step();
        int w;
        logic acc, rel;
        drive();
        #1;
        e_ack = '0;
        if (m_owner >= 0 && v_req[m_owner] && !full) e_ack[m_owner] = 1'b1;
        e_cnt = '0;
`ifdef FIFO_WR_ARB_STATS_EN
        for (int i = 0; i < N; i++) e_cnt[i*16 +: 16] = 16'(m_cnt[i]);
`endif
        chk("gnt",      64'(bus.gnt),          (m_owner >= 0) ? 64'(1 << m_owner) : 64'd0);
        chk("owner_id", 64'(bus.owner_id),     (m_owner >= 0) ? 64'(m_owner) : 64'd0);
        chk("ack",      64'(bus.ack),          64'(e_ack));
        chk("wr_en",    64'(bus.fifo_wr_en),   64'(e_ack != '0));
        chk("wr_data",  64'(bus.fifo_wr_data), (m_owner >= 0) ? 64'(v_dat[m_owner*DW +: DW]) : 64'd0);
        chk("wr_cnt",   64'(bus.wr_cnt),       e_cnt);
        chk("gnt_onehot0",  64'($onehot0(bus.gnt)), 64'd1);
        chk("ack_onehot0",  64'($onehot0(bus.ack)), 64'd1);
        chk("wr_when_full", 64'(bus.fifo_wr_en & bus.fifo_full), 64'd0);
        if (bus.fifo_wr_en) wr_seen++;
        @(posedge clk);
        acc = (e_ack != '0);
        if (m_owner < 0) begin
            w = pick(v_req, m_ptr);
            if (w >= 0) begin
                m_owner = w;
                m_burst = 0;
            end
        end else begin
            rel = !v_req[m_owner] || (acc && m_burst == MB - 1);
            if (rel) begin
                m_ptr   = m_owner;
                m_owner = pick(v_req, m_owner);
                m_burst = 0;
            end else if (acc) begin
                m_burst++;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (e_ack[i]) begin
                rem[i]--;
                cur[i] = 8'($urandom);
                if (m_cnt[i] < 65535) m_cnt[i]++;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        full    = 1'b0;
        for (int i = 0; i < N; i++) rem[i] = 0;
        drive();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic rand_stim();
        for (int i = 0; i < N; i++) begin
            if (rem[i] == 0 && $urandom_range(3) == 0) rem[i] = $urandom_range(8, 1);
            else if (rem[i] > 0 && $urandom_range(31) == 0) rem[i] = 0;
        end
        full = ($urandom_range(4) == 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) cur[i] = 8'($urandom);
        do_reset();
        chk("rst_gnt",   64'(bus.gnt), 64'd0);
        chk("rst_owner", 64'(bus.owner_id), 64'd0);
        chk("rst_cnt",   64'(bus.wr_cnt), 64'd0);

        // Single requester, 6 words: burst of 4 then bubble-free re-grant.
        rem[2] = 6;
        wr_seen = 0;
        step();
        chk("s1_gnt", 64'(bus.gnt), 64'b0100);
        repeat (7) step();
        chk("s1_writes", 64'(wr_seen), 64'd6);
        chk("s1_idle",   64'(bus.gnt), 64'd0);

        // All four requesting continuously.
        do_reset();
        for (int i = 0; i < N; i++) rem[i] = 1000;
        step();
        wr_seen = 0;
        repeat (20) step();
        chk("s2_writes", 64'(wr_seen), 64'd20);
        chk("s2_gnt",    64'(bus.gnt), 64'b0010);

        // Stall for 5 cycles mid-burst.
        do_reset();
        rem[1] = 6;
        wr_seen = 0;
        for (int c = 0; c < 14; c++) begin
            full = (c >= 3 && c <= 7);
            if (c == 3) begin
                chk("s3_pre_writes", 64'(wr_seen), 64'd2);
                wr_seen = 0;
            end
            if (c == 8) begin
                chk("s3_full_writes", 64'(wr_seen), 64'd0);
                chk("s3_gnt_held",    64'(bus.gnt), 64'b0010);
            end
            step();
        end
        chk("s3_total", 64'(wr_seen), 64'd4);

        // Owner drops after 2 writes: direct hand-off to requester 0.
        do_reset();
        rem[3] = 2;
        step();
        rem[0] = 5;
        repeat (3) step();
        chk("s4_gnt", 64'(bus.gnt), 64'b0001);
        repeat (6) step();

        // Asynchronous reset in the middle of a burst.
        do_reset();
        rem[0] = 10;
        rem[2] = 10;
        repeat (3) step();
        drive();
        #2;
        reset_n = 1'b0;
        #1;
        chk("s5_gnt",   64'(bus.gnt), 64'd0);
        chk("s5_wr_en", 64'(bus.fifo_wr_en), 64'd0);
        chk("s5_ack",   64'(bus.ack), 64'd0);
        for (int i = 0; i < N; i++) rem[i] = 0;
        rem[1] = 3;
        rem[3] = 3;
        drive();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        step();
        chk("s5_first", 64'(bus.gnt), 64'b0010);
        repeat (8) step();

        // Randomised traffic against the model.
        do_reset();
        repeat (3000) begin
            rand_stim();
            step();
        end

        // Long stream from requester 0 to reach counter saturation.
        full = 1'b0;
        for (int i = 0; i < N; i++) rem[i] = 0;
        rem[0] = 100000;
        repeat (70002) step();
`ifdef FIFO_WR_ARB_STATS_EN
        chk("stats_sat", 64'(bus.wr_cnt[15:0]), 64'hFFFF);
`else
        chk("stats_off", 64'(bus.wr_cnt), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
